layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have parameter SIZE_address_pix, default 13, meaning the pixel RAM address width.
REQ-002 The block SHALL have parameter picture_size, default 28, meaning the input image edge length.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the watchdog limit per engine run.
REQ-004 The block SHALL have the following ports, as "name direction width meaning":
- clk  in  1  clock; one clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- GO  in  1  start one inference.
- step_in  in  5  loader progress count.
- load_done  in  1  weight load for the current layer is complete.
- nextstep  out  1  one-cycle weight-load request to the loader.
- conv_en, maxp_en, dense_en, result_en  out  1 each  engine enables, level.
- STOP_conv, STOP_maxp, STOP_dense, STOP_res  in  1 each  engine done.
- memstartp, memstartzap  out  SIZE_address_pix  read and write base addresses.
- matrix  out  5  feature-map edge.
- mem, filt  out  5 each  input and output channel limits.
- rep_idx  out  3  maxp repetition index.
- globmaxp_en  out  1  global-max flag.
- in_dense  out  5  dense input count.
- out_dense  out  4  dense output count.
- res_in  in  4  result engine class.
- RESULT  out  4  class index.
- STOP  out  1  inference complete.
- seq_err  out  1  watchdog fired.

Function
REQ-005 The block SHALL execute a fixed 10-entry program, layers 0..9:
- 0 CONV m28 mem3 filt0
- 1 CONV m28 mem3 filt3
- 2 MAXP m28 reps4
- 3 CONV m14 mem7 filt3
- 4 CONV m14 mem7 filt7
- 5 MAXP m14 reps8
- 6 CONV m7 mem15 filt7
- 7 CONV m7 mem15 filt15 glob
- 8 DENSE in16 out11
- 9 RESULT
REQ-006 The block SHALL implement FSM states IDLE, LOAD_REQ, LOAD_WAIT, RUN, WAIT_DONE, ADVANCE, DONE.
REQ-007 From IDLE or DONE, GO=1 SHALL clear STOP, set layer=0 and pix_sel=0, and enter LOAD_REQ; GO SHALL be ignored in all other states.
REQ-008 In LOAD_REQ, for CONV and DENSE layers, nextstep SHALL pulse for exactly one cycle and the FSM SHALL enter LOAD_WAIT; MAXP and RESULT layers SHALL go directly to RUN.
REQ-009 LOAD_WAIT SHALL hold until load_done=1 is sampled, then enter RUN on the next cycle.
REQ-010 In RUN, the layer's single enable and its descriptor outputs SHALL be driven, then the FSM SHALL enter WAIT_DONE; descriptor outputs SHALL be stable throughout while the enable is high.
REQ-011 In WAIT_DONE, when the matching STOP_* is sampled high, the enable SHALL drop on the next cycle and stay low for at least one cycle before any re-assertion.
REQ-012 Addressing SHALL use buffer A = 0 and buffer B = picture_size*picture_size*4 (3136):
- memstartp = pix_sel ? B : A; memstartzap = the other buffer.
- For MAXP only, memstartp SHALL add rep_idx*matrix², and memstartzap SHALL add rep_idx*(matrix²>>2).
- All address sums SHALL be truncated to SIZE_address_pix bits.
REQ-013 A MAXP layer SHALL run reps times, with rep_idx 0..reps-1; all other layers SHALL run once with rep_idx=0.
REQ-014 ADVANCE SHALL toggle pix_sel after CONV, MAXP (after its last rep) and DENSE layers, increment layer, and go to LOAD_REQ; after layer 9 it SHALL go to DONE instead.
REQ-015 On STOP_res, RESULT SHALL capture res_in and STOP SHALL be set to 1; RESULT SHALL read 4'b1111 whenever STOP=0.
REQ-016 globmaxp_en SHALL be 1 only while layer 7's enable is high.
REQ-017 Only one engine enable SHALL ever be high in any cycle.
REQ-018 A STOP_* input that does not match the current layer SHALL be ignored.

Reset
REQ-019 When rst_n=0 at a clk edge, all of the following SHALL hold, and this SHALL take effect mid-operation:
- FSM goes to IDLE.
- All enables, nextstep, globmaxp_en and seq_err = 0.
- STOP = 1 and RESULT = 4'b1111.
- layer, rep_idx and pix_sel = 0.
- memstartp, memstartzap, matrix, mem, filt, in_dense and out_dense = 0.

Configuration
REQ-020 With LAYER_SEQ_WATCHDOG_EN defined, a counter SHALL run in LOAD_WAIT and WAIT_DONE; on reaching TIMEOUT_CYCLES it SHALL drop all enables, set seq_err=1 (sticky until GO or reset), set STOP=1 with RESULT=4'b1111, and enter IDLE.
REQ-021 Without LAYER_SEQ_WATCHDOG_EN, no counter SHALL exist, the block SHALL wait indefinitely, and seq_err SHALL be tied to 0.

Structure
REQ-022 The op-code enum (CONV, MAXP, DENSE, RESULT), the descriptor struct, the 10-entry program constant, and the buffer bases SHALL reside in the shared package neuroset_pkg.
REQ-023 Descriptor decode SHALL be a sub-module layer_rom: combinational, indexed by layer, returning the descriptor.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then check outputs -> STOP=1, RESULT=4'b1111, all enables 0, seq_err=0.
- GO with model engines (done after 20 cycles, load_done after 5, res_in=7) -> enable order conv×2, maxp×4, conv×2, maxp×8, conv×2, dense, result; nextstep count 7; STOP=1; RESULT=7.
- Layer 5 maxp rep 3 -> memstartp=3136+3*196=3724; memstartzap=0+3*49=147.
- GO pulsed during layer 4 -> no effect; sequence unchanged.
- rst_n=0 during layer 3 WAIT_DONE -> next cycle IDLE, conv_en=0; a later GO restarts at layer 0.
- With the macro and TIMEOUT_CYCLES=100, STOP_conv withheld -> at cycle 100 seq_err=1, conv_en=0, STOP=1.

Source files
------------

// File: rtl/neuroset_pkg.sv
// Shared definitions for the layer sequencer: op-codes, the layer
// descriptor, the fixed 10-layer inference program and the ping-pong
// feature-map buffer bases.
package neuroset_pkg;

  typedef enum logic [1:0] {
    OP_CONV   = 2'd0,
    OP_MAXP   = 2'd1,
    OP_DENSE  = 2'd2,
    OP_RESULT = 2'd3
  } op_e;

  // One program entry. reps is 1 for every non-MAXP layer.
  typedef struct packed {
    op_e        op;
    logic [4:0] matrix;
    logic [4:0] mem;
    logic [4:0] filt;
    logic [3:0] reps;
    logic       glob;
    logic [4:0] in_dense;
    logic [3:0] out_dense;
  } layer_desc_t;

  localparam int NUM_LAYERS           = 10;
  localparam int DEFAULT_PICTURE_SIZE = 28;

  // Buffer A always starts at zero; buffer B sits after a full
  // picture_size x picture_size map with four words per pixel.
  localparam int BUF_A_BASE = 0;

  function automatic int buf_b_base(input int pic);
    return pic * pic * 4;
  endfunction

  localparam int BUF_B_BASE = buf_b_base(DEFAULT_PICTURE_SIZE);

  //   op         matrix mem    filt   reps  glob  in_d   out_d
  localparam layer_desc_t PROGRAM [NUM_LAYERS] = '{
    '{OP_CONV,   5'd28, 5'd3,  5'd0,  4'd1, 1'b0, 5'd0,  4'd0 },
    '{OP_CONV,   5'd28, 5'd3,  5'd3,  4'd1, 1'b0, 5'd0,  4'd0 },
    '{OP_MAXP,   5'd28, 5'd0,  5'd0,  4'd4, 1'b0, 5'd0,  4'd0 },
    '{OP_CONV,   5'd14, 5'd7,  5'd3,  4'd1, 1'b0, 5'd0,  4'd0 },
    '{OP_CONV,   5'd14, 5'd7,  5'd7,  4'd1, 1'b0, 5'd0,  4'd0 },
    '{OP_MAXP,   5'd14, 5'd0,  5'd0,  4'd8, 1'b0, 5'd0,  4'd0 },
    '{OP_CONV,   5'd7,  5'd15, 5'd7,  4'd1, 1'b0, 5'd0,  4'd0 },
    '{OP_CONV,   5'd7,  5'd15, 5'd15, 4'd1, 1'b1, 5'd0,  4'd0 },
    '{OP_DENSE,  5'd0,  5'd0,  5'd0,  4'd1, 1'b0, 5'd16, 4'd11},
    '{OP_RESULT, 5'd0,  5'd0,  5'd0,  4'd1, 1'b0, 5'd0,  4'd0 }
  };

  // One-hot engine enable vector {result, dense, maxp, conv} for an op.
  function automatic logic [3:0] op_enable(input op_e op);
    case (op)
      OP_CONV:   return 4'b0001;
      OP_MAXP:   return 4'b0010;
      OP_DENSE:  return 4'b0100;
      default:   return 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/layer_rom.sv
// Combinational descriptor lookup: layer index -> program entry.
// Indices past the end of the program return an all-zero descriptor.
module layer_rom
  import neuroset_pkg::*;
(
  input  logic [3:0]  layer_i,
  output layer_desc_t desc_o
);

  // Table lookup with a safe default for unused indices.
  always_comb begin
    desc_o = '0;
    if (layer_i < 4'(NUM_LAYERS)) desc_o = PROGRAM[layer_i];
  end

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the fixed inference program, requesting weight
// loads, enabling one engine at a time with its descriptor, ping-ponging
// the feature-map buffers and capturing the final class.
// Optional watchdog: define LAYER_SEQ_WATCHDOG_EN to abort a run whose
// loader or engine stalls for TIMEOUT_CYCLES cycles.
//
// Handshake: an engine enable is a level; it rises when the FSM leaves
// RUN and stays high, with its descriptor outputs frozen, until the
// matching STOP_* is sampled high, then drops for at least one cycle.
// nextstep is a single-cycle request; load_done is sampled as a level.
module layer_sequencer
  import neuroset_pkg::*;
#(
  parameter int SIZE_address_pix = 13,
  parameter int picture_size     = 28,
  parameter int TIMEOUT_CYCLES   = 65535
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        GO,
  input  logic [4:0]                  step_in,
  input  logic                        load_done,
  output logic                        nextstep,
  output logic                        conv_en,
  output logic                        maxp_en,
  output logic                        dense_en,
  output logic                        result_en,
  input  logic                        STOP_conv,
  input  logic                        STOP_maxp,
  input  logic                        STOP_dense,
  input  logic                        STOP_res,
  output logic [SIZE_address_pix-1:0] memstartp,
  output logic [SIZE_address_pix-1:0] memstartzap,
  output logic [4:0]                  matrix,
  output logic [4:0]                  mem,
  output logic [4:0]                  filt,
  output logic [2:0]                  rep_idx,
  output logic                        globmaxp_en,
  output logic [4:0]                  in_dense,
  output logic [3:0]                  out_dense,
  input  logic [3:0]                  res_in,
  output logic [3:0]                  RESULT,
  output logic                        STOP,
  output logic                        seq_err,
  output logic [2:0]                  dbg_state_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_REQ  = 3'd1;
  localparam logic [2:0] S_LOAD_WAIT = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_ADVANCE   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  localparam logic [31:0] BUF_A      = 32'(BUF_A_BASE);
  localparam logic [31:0] BUF_B      = 32'(buf_b_base(picture_size));
  localparam logic [3:0]  LAST_LAYER = 4'(NUM_LAYERS - 1);

  logic [2:0]                  state_q, state_d;
  logic [3:0]                  layer_q, layer_d;
  logic [2:0]                  rep_q, rep_d;
  logic                        pix_sel_q, pix_sel_d;
  logic                        nextstep_q, nextstep_d;
  logic [3:0]                  en_q, en_d;
  logic                        glob_q, glob_d;
  logic                        stop_q, stop_d;
  logic [3:0]                  result_q, result_d;
  logic [SIZE_address_pix-1:0] memp_q, memp_d, memz_q, memz_d;
  logic [4:0]                  matrix_q, matrix_d, mem_q, mem_d, filt_q, filt_d;
  logic [4:0]                  in_dense_q, in_dense_d;
  logic [3:0]                  out_dense_q, out_dense_d;

  layer_desc_t desc;
  logic        go_accept;
  logic        stop_match;
  logic        wd_fire;
  logic [31:0] sq, base_p, base_z, off_p, off_z;

  // Loader progress is informational only; the sequencer keys off load_done.
  logic unused_step;
  assign unused_step = ^step_in;

  layer_rom u_rom (
    .layer_i (layer_q),
    .desc_o  (desc)
  );

  assign go_accept = GO && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Done strobe from the engine that owns the current layer; others are ignored.
  always_comb begin
    case (desc.op)
      OP_CONV:  stop_match = STOP_conv;
      OP_MAXP:  stop_match = STOP_maxp;
      OP_DENSE: stop_match = STOP_dense;
      default:  stop_match = STOP_res;
    endcase
  end

  // Read/write base addresses; MAXP reps walk through quarter-size output tiles.
  always_comb begin
    sq     = 32'(desc.matrix) * 32'(desc.matrix);
    base_p = pix_sel_q ? BUF_B : BUF_A;
    base_z = pix_sel_q ? BUF_A : BUF_B;
    off_p  = (desc.op == OP_MAXP) ? 32'(rep_q) * sq : 32'd0;
    off_z  = (desc.op == OP_MAXP) ? 32'(rep_q) * (sq >> 2) : 32'd0;
  end

`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_counting;
  logic            seq_err_q, seq_err_d;

  // Count consecutive cycles spent waiting on the loader or an engine.
  always_comb begin
    wd_counting = (state_q == S_LOAD_WAIT) || (state_q == S_WAIT_DONE);
    wd_fire     = wd_counting && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_cnt_d    = (wd_counting && !wd_fire) ? wd_cnt_q + WD_W'(1) : '0;
    seq_err_d   = seq_err_q;
    if (go_accept) seq_err_d = 1'b0;
    if (wd_fire)   seq_err_d = 1'b1;
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      seq_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign wd_fire = 1'b0;
  assign seq_err = 1'b0;
`endif

  // Sequencer next-state and registered output decode.
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    rep_d       = rep_q;
    pix_sel_d   = pix_sel_q;
    nextstep_d  = 1'b0;
    en_d        = en_q;
    glob_d      = glob_q;
    stop_d      = stop_q;
    result_d    = result_q;
    memp_d      = memp_q;
    memz_d      = memz_q;
    matrix_d    = matrix_q;
    mem_d       = mem_q;
    filt_d      = filt_q;
    in_dense_d  = in_dense_q;
    out_dense_d = out_dense_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_accept) begin
          stop_d    = 1'b0;
          layer_d   = '0;
          rep_d     = '0;
          pix_sel_d = 1'b0;
          state_d   = S_LOAD_REQ;
        end
      end
      S_LOAD_REQ: begin
        if ((desc.op == OP_CONV) || (desc.op == OP_DENSE)) begin
          nextstep_d = 1'b1;
          state_d    = S_LOAD_WAIT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_LOAD_WAIT: begin
        if (load_done) state_d = S_RUN;
      end
      S_RUN: begin
        en_d        = op_enable(desc.op);
        glob_d      = desc.glob;
        memp_d      = SIZE_address_pix'(base_p + off_p);
        memz_d      = SIZE_address_pix'(base_z + off_z);
        matrix_d    = desc.matrix;
        mem_d       = desc.mem;
        filt_d      = desc.filt;
        in_dense_d  = desc.in_dense;
        out_dense_d = desc.out_dense;
        state_d     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (stop_match) begin
          en_d   = '0;
          glob_d = 1'b0;
          if (desc.op == OP_RESULT) begin
            result_d = res_in;
            stop_d   = 1'b1;
          end
          state_d = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if ((desc.op == OP_MAXP) && ({1'b0, rep_q} != (desc.reps - 4'd1))) begin
          rep_d   = rep_q + 3'd1;
          state_d = S_RUN;
        end else begin
          rep_d = '0;
          if (desc.op != OP_RESULT) pix_sel_d = ~pix_sel_q;
          if (layer_q == LAST_LAYER) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + 4'd1;
            state_d = S_LOAD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled run is abandoned: engines released, result invalidated.
    if (wd_fire) begin
      en_d       = '0;
      glob_d     = 1'b0;
      nextstep_d = 1'b0;
      stop_d     = 1'b1;
      result_d   = 4'hF;
      state_d    = S_IDLE;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      layer_q     <= '0;
      rep_q       <= '0;
      pix_sel_q   <= 1'b0;
      nextstep_q  <= 1'b0;
      en_q        <= '0;
      glob_q      <= 1'b0;
      stop_q      <= 1'b1;
      result_q    <= 4'hF;
      memp_q      <= '0;
      memz_q      <= '0;
      matrix_q    <= '0;
      mem_q       <= '0;
      filt_q      <= '0;
      in_dense_q  <= '0;
      out_dense_q <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      rep_q       <= rep_d;
      pix_sel_q   <= pix_sel_d;
      nextstep_q  <= nextstep_d;
      en_q        <= en_d;
      glob_q      <= glob_d;
      stop_q      <= stop_d;
      result_q    <= result_d;
      memp_q      <= memp_d;
      memz_q      <= memz_d;
      matrix_q    <= matrix_d;
      mem_q       <= mem_d;
      filt_q      <= filt_d;
      in_dense_q  <= in_dense_d;
      out_dense_q <= out_dense_d;
    end
  end

  assign nextstep    = nextstep_q;
  assign conv_en     = en_q[0];
  assign maxp_en     = en_q[1];
  assign dense_en    = en_q[2];
  assign result_en   = en_q[3];
  assign globmaxp_en = glob_q;
  assign memstartp   = memp_q;
  assign memstartzap = memz_q;
  assign matrix      = matrix_q;
  assign mem         = mem_q;
  assign filt        = filt_q;
  assign rep_idx     = rep_q;
  assign in_dense    = in_dense_q;
  assign out_dense   = out_dense_q;
  assign STOP        = stop_q;
  assign RESULT      = stop_q ? result_q : 4'hF;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: model loader and engines, a table of
// expected engine runs, and hand-written reset / GO / watchdog sequences.
// Define LAYER_SEQ_WATCHDOG_EN to build the watchdog variant (timeout 100).
`timescale 1ns/1ps
module tb_layer_sequencer;
  import neuroset_pkg::*;

`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam int TB_TIMEOUT = 100;
`else
  localparam int TB_TIMEOUT = 65535;
`endif
  localparam int AW         = 13;
  localparam int ENG_LAT    = 20;
  localparam int LOAD_LAT   = 5;
  localparam int RUN_BUDGET = 4000;
  localparam int NRUNS      = 20;
  localparam int OBS_DEPTH  = 256;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd6;
  localparam logic [3:0] E_CONV = 4'b0001, E_MAXP = 4'b0010, E_DENSE = 4'b0100, E_RES = 4'b1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  initial forever #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          GO = 1'b0;
  logic [4:0]    step_in = 5'd0;
  logic          load_done = 1'b0;
  logic          nextstep, conv_en, maxp_en, dense_en, result_en;
  logic          STOP_conv = 1'b0, STOP_maxp = 1'b0, STOP_dense = 1'b0, STOP_res = 1'b0;
  logic [AW-1:0] memstartp, memstartzap;
  logic [4:0]    matrix, mem, filt, in_dense;
  logic [2:0]    rep_idx;
  logic          globmaxp_en;
  logic [3:0]    out_dense;
  logic [3:0]    res_in = 4'd7;
  logic [3:0]    RESULT;
  logic          STOP, seq_err;
  logic [2:0]    dbg_state;

  layer_sequencer #(
    .SIZE_address_pix (AW),
    .picture_size     (28),
    .TIMEOUT_CYCLES   (TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .GO(GO), .step_in(step_in), .load_done(load_done),
    .nextstep(nextstep), .conv_en(conv_en), .maxp_en(maxp_en), .dense_en(dense_en),
    .result_en(result_en), .STOP_conv(STOP_conv), .STOP_maxp(STOP_maxp),
    .STOP_dense(STOP_dense), .STOP_res(STOP_res), .memstartp(memstartp),
    .memstartzap(memstartzap), .matrix(matrix), .mem(mem), .filt(filt),
    .rep_idx(rep_idx), .globmaxp_en(globmaxp_en), .in_dense(in_dense),
    .out_dense(out_dense), .res_in(res_in), .RESULT(RESULT), .STOP(STOP),
    .seq_err(seq_err), .dbg_state_o(dbg_state)
  );

  // ---------------- run records ----------------
  typedef struct packed {
    logic [3:0]    en;
    logic [2:0]    rep;
    logic [AW-1:0] p;
    logic [AW-1:0] z;
    logic [4:0]    matrix;
    logic [4:0]    mem;
    logic [4:0]    filt;
    logic          glob;
    logic [4:0]    in_d;
    logic [3:0]    out_d;
  } run_rec_t;
  localparam int RW = $bits(run_rec_t);

  run_rec_t        tbl [NRUNS];
  logic [RW-1:0]   exp_q[$];

  function automatic run_rec_t mk(input logic [3:0] en, input int rep, input int p, input int z,
                                  input int m, input int mm, input int f, input bit g,
                                  input int ind, input int outd);
    run_rec_t r;
    r.en = en; r.rep = 3'(rep); r.p = AW'(p); r.z = AW'(z);
    r.matrix = 5'(m); r.mem = 5'(mm); r.filt = 5'(f); r.glob = g;
    r.in_d = 5'(ind); r.out_d = 4'(outd);
    return r;
  endfunction

  // ---------------- model loader ----------------
  int ld_cnt = 0;
  always @(negedge clk) begin
    load_done = 1'b0;
    if (ld_cnt > 0) begin
      ld_cnt++;
      if (ld_cnt == LOAD_LAT + 1) begin
        load_done = 1'b1;
        ld_cnt = 0;
      end
    end
    if (nextstep) ld_cnt = 1;
  end

  // ---------------- model engines ----------------
  logic [3:0] en_vec;
  assign en_vec = {result_en, dense_en, maxp_en, conv_en};
  bit withhold_conv = 1'b0;
  int eng_cnt = 0;
  bit eng_fired = 1'b0;
  always @(negedge clk) begin
    STOP_conv = 1'b0; STOP_maxp = 1'b0; STOP_dense = 1'b0; STOP_res = 1'b0;
    if (en_vec == 4'd0) begin
      eng_cnt = 0;
      eng_fired = 1'b0;
    end else if (!eng_fired) begin
      eng_cnt++;
      // a foreign done strobe mid-run must be ignored
      if (eng_cnt == 5) begin
        STOP_maxp = conv_en; STOP_dense = maxp_en; STOP_res = dense_en; STOP_conv = result_en;
      end
      if (eng_cnt == ENG_LAT) begin
        eng_fired = 1'b1;
        STOP_conv = conv_en && !withhold_conv; STOP_maxp = maxp_en;
        STOP_dense = dense_en; STOP_res = result_en;
      end
    end
  end

  // ---------------- monitor ----------------
  run_rec_t obs_mem [OBS_DEPTH];
  run_rec_t cur_rec, prev_rec;
  logic [3:0] prev_en = 4'd0;
  int mon_runs = 0, ns_total = 0, onehot_bad = 0, glob_bad = 0, result_bad = 0, stable_bad = 0;
  always @(negedge clk) begin
    cur_rec = '{en_vec, rep_idx, memstartp, memstartzap, matrix, mem, filt, globmaxp_en, in_dense, out_dense};
    if (nextstep) ns_total++;
    if ($countones(en_vec) > 1) onehot_bad++;
    if (globmaxp_en && !conv_en) glob_bad++;
    if (!STOP && RESULT != 4'hF) result_bad++;
    if (en_vec != 4'd0 && prev_en == en_vec && cur_rec != prev_rec) stable_bad++;
    if (en_vec != 4'd0 && prev_en == 4'd0) begin
      if (mon_runs < OBS_DEPTH) obs_mem[mon_runs] = cur_rec;
      mon_runs++;
    end
    prev_en = en_vec;
    prev_rec = cur_rec;
  end

  // ---------------- scoreboard / driver tasks ----------------
  int n_cmp = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_go();
    GO = 1'b1;
    @(negedge clk);
    GO = 1'b0;
  endtask

  function automatic int bad_sum();
    return onehot_bad + glob_bad + result_bad + stable_bad;
  endfunction

  // Full inference; optionally pulses GO again once run index go_at_run starts.
  task automatic run_to_done(input int go_at_run, input string tag, output int base);
    int cyc, ns0, bad0, idx;
    bit go_sent;
    logic [RW-1:0] got, exp;
    base = mon_runs; ns0 = ns_total; bad0 = bad_sum(); go_sent = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NRUNS; i++) exp_q.push_back(tbl[i]);
    pulse_go();
    check({tag, "_stop_low"}, 64'(STOP), 64'd0);
    cyc = 0;
    while (!(STOP && dbg_state == ST_DONE) && cyc < RUN_BUDGET) begin
      if (go_at_run >= 0 && (mon_runs - base) == go_at_run + 1 && !go_sent) begin
        GO = 1'b1; go_sent = 1'b1;
      end else GO = 1'b0;
      @(negedge clk);
      cyc++;
    end
    GO = 1'b0;
    check({tag, "_finished_in_budget"}, 64'(cyc < RUN_BUDGET), 64'd1);
    for (int i = 0; i < NRUNS; i++) begin
      idx = base + i;
      exp = exp_q.pop_front();
      got = (idx < mon_runs && idx < OBS_DEPTH) ? obs_mem[idx] : '0;
      check($sformatf("%s_run%0d", tag, i), 64'(got), 64'(exp));
    end
    check({tag, "_run_count"}, 64'(mon_runs - base), 64'(NRUNS));
    check({tag, "_nextstep_count"}, 64'(ns_total - ns0), 64'd7);
    check({tag, "_STOP"}, 64'(STOP), 64'd1);
    check({tag, "_RESULT"}, 64'(RESULT), 64'd7);
    check({tag, "_seq_err"}, 64'(seq_err), 64'd0);
    check({tag, "_protocol_violations"}, 64'(bad_sum() - bad0), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int b, cyc;

    // expected engine runs for one inference (B = 3136)
    tbl[0]  = mk(E_CONV, 0, 0,    3136, 28, 3, 0, 0, 0, 0);
    tbl[1]  = mk(E_CONV, 0, 3136, 0,    28, 3, 3, 0, 0, 0);
    for (int r = 0; r < 4; r++) tbl[2 + r] = mk(E_MAXP, r, r * 784, 3136 + r * 196, 28, 0, 0, 0, 0, 0);
    tbl[6]  = mk(E_CONV, 0, 3136, 0,    14, 7, 3, 0, 0, 0);
    tbl[7]  = mk(E_CONV, 0, 0,    3136, 14, 7, 7, 0, 0, 0);
    for (int r = 0; r < 8; r++) tbl[8 + r] = mk(E_MAXP, r, 3136 + r * 196, r * 49, 14, 0, 0, 0, 0, 0);
    tbl[16] = mk(E_CONV, 0, 0,    3136, 7, 15, 7,  0, 0, 0);
    tbl[17] = mk(E_CONV, 0, 3136, 0,    7, 15, 15, 1, 0, 0);
    tbl[18] = mk(E_DENSE, 0, 0,   3136, 0, 0,  0,  0, 16, 11);
    tbl[19] = mk(E_RES,  0, 3136, 0,    0, 0,  0,  0, 0, 0);

    // reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_STOP", 64'(STOP), 64'd1);
    check("rst_RESULT", 64'(RESULT), 64'hF);
    check("rst_enables", 64'(en_vec), 64'd0);
    check("rst_seq_err", 64'(seq_err), 64'd0);
    check("rst_nextstep_glob", 64'({nextstep, globmaxp_en}), 64'd0);
    check("rst_addr", 64'({memstartp, memstartzap}), 64'd0);
    check("rst_desc", 64'({matrix, mem, filt, rep_idx, in_dense, out_dense}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;
    tick(2);
    check("idle_hold", 64'(dbg_state), 64'(ST_IDLE));

    // full inference
    run_to_done(-1, "full", b);
    check("l5_rep3_memstartp", 64'(obs_mem[(b + 11) % OBS_DEPTH].p), 64'd3724);
    check("l5_rep3_memstartzap", 64'(obs_mem[(b + 11) % OBS_DEPTH].z), 64'd147);

    // GO during layer 4 is ignored
    run_to_done(7, "go_mid", b);

    // reset during layer 3 WAIT_DONE
    b = mon_runs;
    pulse_go();
    cyc = 0;
    while ((mon_runs - b) < 7 && cyc < RUN_BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_reached_layer3", 64'(mon_runs - b), 64'd7);
    tick(3);
    check("mid_conv_busy", 64'(conv_en), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_rst_conv_en", 64'(conv_en), 64'd0);
    check("mid_rst_STOP_RESULT", 64'({STOP, RESULT}), 64'h1F);
    check("mid_rst_desc", 64'({memstartp, matrix, rep_idx}), 64'd0);
    rst_n = 1'b1;
    tick(2);
    check("mid_idle_hold", 64'(dbg_state), 64'(ST_IDLE));
    run_to_done(-1, "restart", b);

`ifdef LAYER_SEQ_WATCHDOG_EN
    // withheld STOP_conv trips the watchdog 100 cycles after conv_en rises
    withhold_conv = 1'b1;
    pulse_go();
    cyc = 0;
    while (!conv_en && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("wd_conv_rise", 64'(conv_en), 64'd1);
    tick(TB_TIMEOUT - 1);
    check("wd_pre_seq_err", 64'(seq_err), 64'd0);
    check("wd_pre_conv_en", 64'(conv_en), 64'd1);
    tick(1);
    check("wd_seq_err", 64'(seq_err), 64'd1);
    check("wd_conv_en", 64'(conv_en), 64'd0);
    check("wd_STOP_RESULT", 64'({STOP, RESULT}), 64'h1F);
    check("wd_state", 64'(dbg_state), 64'(ST_IDLE));
    tick(3);
    check("wd_sticky", 64'(seq_err), 64'd1);
    withhold_conv = 1'b0;
    pulse_go();
    check("wd_go_clears", 64'(seq_err), 64'd0);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
